// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between two pipelined CPUs.
// Registered read return per port, plus saturating per-port stall counters.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              stall0_o,
  output logic              stall1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  wait0_o,
  output logic [CNT_W-1:0]  wait1_o
);

  // Handshake: reqN_i acts as valid and ~stallN_o as ready. An access is
  // performed in exactly the cycle where req is high and stall is low; a
  // stalled requester holds req/we/addr/wdata until that cycle comes.
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [CNT_W-1:0]  wait0_q, wait0_d, wait1_q, wait1_d;
  logic              gnt0, gnt1;

  // On a tie the port that did not win last time is served.
  assign gnt0 = req0_i & (~req1_i | last_grant_q);
  assign gnt1 = req1_i & (~req0_i | ~last_grant_q);

  assign stall0_o = req0_i & ~gnt0;
  assign stall1_o = req1_i & ~gnt1;

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    if (gnt0) begin
      mem_addr_o  = addr0_i;
      mem_wdata_o = wdata0_i;
      mem_write_o = we0_i;
      mem_read_o  = ~we0_i;
    end else if (gnt1) begin
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
      mem_write_o = we1_i;
      mem_read_o  = ~we1_i;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;
    wait0_d      = wait0_q;
    wait1_d      = wait1_q;
    if (gnt0) begin
      last_grant_d = 1'b0;
      if (!we0_i) begin
        rdata0_d  = mem_rdata_i;
        rvalid0_d = 1'b1;
      end
    end else if (gnt1) begin
      last_grant_d = 1'b1;
      if (!we1_i) begin
        rdata1_d  = mem_rdata_i;
        rvalid1_d = 1'b1;
      end
    end
    // Counters stick at all-ones rather than wrapping.
    if (stall0_o && (wait0_q != {CNT_W{1'b1}})) wait0_d = wait0_q + CNT_W'(1);
    if (stall1_o && (wait1_q != {CNT_W{1'b1}})) wait1_d = wait1_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      wait0_q      <= '0;
      wait1_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      wait0_q      <= wait0_d;
      wait1_q      <= wait1_d;
    end
  end

  assign rdata0_o  = rdata0_q;
  assign rdata1_o  = rdata1_q;
  assign rvalid0_o = rvalid0_q;
  assign rvalid1_o = rvalid1_q;
  assign wait0_o   = wait0_q;
  assign wait1_o   = wait1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        stall0, stall1, rvalid0, rvalid1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [15:0] wait0, wait1;
  logic        s_stall0, s_stall1, s_rvalid0, s_rvalid1, s_mem_read, s_mem_write;
  logic [31:0] s_rdata0, s_rdata1, s_mem_addr, s_mem_wdata;
  logic [3:0]  s_wait0, s_wait1;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n(rst_n), .req0_i(req0), .req1_i(req1),
    .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .stall0_o(stall0), .stall1_o(stall1),
    .rdata0_o(rdata0), .rdata1_o(rdata1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rdata_i(mem_rdata), .wait0_o(wait0), .wait1_o(wait1)
  );

  // Narrow-counter copy on the same inputs, used for the saturation check.
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut_s (
    .clk_i(clk), .rst_n(rst_n), .req0_i(req0), .req1_i(req1),
    .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1), .stall0_o(s_stall0), .stall1_o(s_stall1),
    .rdata0_o(s_rdata0), .rdata1_o(s_rdata1), .rvalid0_o(s_rvalid0), .rvalid1_o(s_rvalid1),
    .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata), .mem_read_o(s_mem_read),
    .mem_write_o(s_mem_write), .mem_rdata_i(mem_rdata), .wait0_o(s_wait0), .wait1_o(s_wait1)
  );

  // Data memory: 16 words, combinational read, write at the clock edge.
  logic [31:0] mem [16] = '{default: 32'h0};
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  assign mem_rdata = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (rst_n && mem_write) mem[mem_addr[5:2]] <= mem_wdata;
  end

  // Reference model state.
  int          m_last, m_wait0, m_wait1, m_rv0, m_rv1, run0, run1, max_run;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] ref_mem [16];
  int          n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int winner();
    if (req0 && req1) return (m_last == 1) ? 0 : 1;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1; m_wait0 = 0; m_wait1 = 0; m_rv0 = 0; m_rv1 = 0;
    m_rd0 = 0; m_rd1 = 0; run0 = 0; run1 = 0;
  endtask

  task automatic model_edge();
    int w;
    w = winner();
    if (req0 && w != 0) begin m_wait0 = (m_wait0 < 65535) ? m_wait0 + 1 : 65535; run0++; end
    else run0 = 0;
    if (req1 && w != 1) begin m_wait1 = (m_wait1 < 65535) ? m_wait1 + 1 : 65535; run1++; end
    else run1 = 0;
    if (run0 > max_run) max_run = run0;
    if (run1 > max_run) max_run = run1;
    m_rv0 = 0; m_rv1 = 0;
    if (w == 0) begin
      if (we0) ref_mem[addr0[5:2]] = wdata0;
      else begin m_rd0 = ref_mem[addr0[5:2]]; m_rv0 = 1; end
    end else if (w == 1) begin
      if (we1) ref_mem[addr1[5:2]] = wdata1;
      else begin m_rd1 = ref_mem[addr1[5:2]]; m_rv1 = 1; end
    end
    if (w >= 0) m_last = w;
  endtask

  task automatic drive(input logic r0, r1, w0, w1, input logic [31:0] a0, a1, d0, d1);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  // One clock: model-checked comb outputs, edge, model-checked registers.
  task automatic cyc(input string tag);
    int          w;
    logic [31:0] ea, ed;
    logic        er, ew;
    #2;
    w = winner();
    ea = 0; ed = 0; er = 0; ew = 0;
    if (w == 0) begin ea = addr0; ed = wdata0; ew = we0; er = !we0; end
    if (w == 1) begin ea = addr1; ed = wdata1; ew = we1; er = !we1; end
    chk({tag, "_comb"}, {stall0, stall1, mem_read, mem_write, mem_addr, mem_wdata},
        {req0 && w != 0, req1 && w != 1, er, ew, ea, ed});
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    chk({tag, "_regs"}, {rvalid0, rvalid1, rdata0, rdata1, wait0, wait1},
        {m_rv0[0], m_rv1[0], m_rd0, m_rd1, m_wait0[15:0], m_wait1[15:0]});
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("reset_regs", {rvalid0, rvalid1, rdata0, rdata1, wait0, wait1}, '0);
    chk("reset_strobes", {mem_read, mem_write, mem_addr}, '0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic s0, s1, rd, wr;
    logic [31:0] ma, md;
  } vec_t;

  vec_t vecs[8];
  logic [5:0] order;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 0;
    max_run = 0;
    model_reset();

    // Preload memory[3] = 77.
    @(negedge clk);
    pre_we = 1; pre_idx = 4'd3; pre_data = 32'd77;
    @(negedge clk);
    pre_we = 0;
    ref_mem[3] = 77;

    // Reset and single read.
    do_reset();
    drive(1, 0, 0, 0, 12, 0, 0, 0);
    #1;
    chk("single_stall0", stall0, 0);
    chk("single_mem_read", mem_read, 1);
    cyc("single");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("single_rdata0", rdata0, 77);
    chk("single_rvalid0", rvalid0, 1);
    cyc("single_idle");
    chk("single_rvalid0_drop", rvalid0, 0);

    // Vector table, applied from a fresh reset (port 0 wins first tie).
    vecs[0] = '{1,0,0,0, 12, 0,    32'h11, 0,     0,0,1,0, 12, 32'h11};
    vecs[1] = '{1,1,1,1, 8,  20,   32'h22, 32'h33, 1,0,0,1, 20, 32'h33};
    vecs[2] = '{1,1,0,0, 4,  16,   32'h44, 32'h55, 0,1,1,0, 4,  32'h44};
    vecs[3] = '{0,0,0,0, 0,  0,    0,      0,      0,0,0,0, 0,  0};
    vecs[4] = '{0,1,0,1, 0,  24,   0,      32'h66, 0,0,0,1, 24, 32'h66};
    vecs[5] = '{1,1,1,0, 28, 0,    32'hAA, 32'hBB, 0,1,0,1, 28, 32'hAA};
    vecs[6] = '{0,1,1,0, 40, 36,   32'h99, 32'h77, 0,0,1,0, 36, 32'h77};
    vecs[7] = '{1,1,0,0, 44, 48,   32'h1,  32'h2,  0,1,1,0, 44, 32'h1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
            vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
      #1;
      chk($sformatf("vec%0d", i), {stall0, stall1, mem_read, mem_write, mem_addr, mem_wdata},
          {vecs[i].s0, vecs[i].s1, vecs[i].rd, vecs[i].wr, vecs[i].ma, vecs[i].md});
      cyc($sformatf("vec%0d", i));
    end

    // First tie after reset: both write address 8.
    do_reset();
    drive(1, 1, 1, 1, 8, 8, 5, 9);
    #1;
    chk("tie_c1", {stall0, stall1}, 2'b01);
    cyc("tie_c1");
    drive(0, 1, 1, 1, 8, 8, 5, 9);
    #1;
    chk("tie_c2", {stall1, mem_write, mem_wdata}, {1'b0, 1'b1, 32'd9});
    cyc("tie_c2");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("tie_idle");
    chk("tie_mem2", mem[2], 9);
    chk("tie_wait1", wait1, 1);

    // Sustained contention: six cycles of reads from both ports.
    do_reset();
    order = '0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 0, 0, 4 * i, 4 * i + 32, 0, 0);
      #1;
      order[5 - i] = stall0;
      cyc("contend");
    end
    chk("contend_order", order, 6'b010101);
    chk("contend_waits", {wait0, wait1}, {16'd3, 16'd3});

    // Saturation: 42 contended cycles give 21 stalls per port.
    do_reset();
    for (int i = 0; i < 42; i++) begin
      drive(1, 1, 0, 0, 0, 4, 0, 0);
      cyc("sat");
    end
    chk("sat_wait1_narrow", s_wait1, 4'd15);
    chk("sat_wait0_narrow", s_wait0, 4'd15);
    chk("sat_wait1_wide", wait1, 16'd21);

    // Reset while port 1 stalled and an rvalid0 pulse pending.
    do_reset();
    drive(1, 1, 0, 0, 12, 16, 0, 0);
    cyc("midrst_pre");
    chk("midrst_pending", {rvalid0, wait1}, {1'b1, 16'd1});
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_cleared", {rvalid0, wait1, rdata0}, {1'b0, 16'd0, 32'd0});
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_tie", {stall0, stall1}, 2'b01);
    cyc("midrst_post");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
            $urandom, $urandom);
      cyc("rand");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rand_tail");
    for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);
    chk("starvation", 32'(max_run > 1), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
